dsp48a1_mac_ctrl: RTL

Sequencer that drives a DSP48A1 instance as an N-term multiply-accumulate engine. Accepts signed 18-bit operand pairs over a valid/ready stream and issues them to the DSP A/B ports. Generates the OPMODE, CE and RST controls, tracks the DSP pipeline latency, then captures P and presents the 48-bit sum on a valid/ready result stream. It is the initiating side of the DSP48A1 port interface.

---
 rtl/dsp48a1_pkg.sv | 18 +
 rtl/dsp_ctrl_pipe.sv | 27 ++
 rtl/dsp48a1_mac_ctrl.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/dsp48a1_pkg.sv
// Shared constants and types for the DSP48A1 MAC sequencer.
// Optional overflow flag is compiled in with DSP48A1_OVF_FLAG_EN.
package dsp48a1_pkg;

    localparam int A_W = 18;
    localparam int P_W = 48;

    localparam logic [7:0] OPMODE_FIRST = 8'b0000_0001;
    localparam logic [7:0] OPMODE_ACC   = 8'b0000_1001;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        HOLD
    } state_e;

endpackage

// File: rtl/dsp_ctrl_pipe.sv
// Clock-enabled shift register that tracks DSP pipeline stages.
// Advances only when the DSP clock enables are high.
module dsp_ctrl_pipe #(
    parameter int W     = 1,
    parameter int DEPTH = 1
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         ce_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] sr_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) sr_q[i] <= '0;
        end else if (ce_i) begin
            sr_q[0] <= d_i;
            for (int i = 1; i < DEPTH; i++) sr_q[i] <= sr_q[i-1];
        end
    end

    assign q_o = sr_q[DEPTH-1];

endmodule

// File: rtl/dsp48a1_mac_ctrl.sv
// N-term MAC sequencer driving a DSP48A1 (A/B, OPMODE, CE, RST; reads P).
// Define DSP48A1_OVF_FLAG_EN to add the sticky res_ovf carry flag.
module dsp48a1_mac_ctrl
    import dsp48a1_pkg::*;
#(
    parameter int N_MAC   = 8,
    parameter int LATENCY = 3,
    parameter int OPM_LAG = 2
) (
    input  logic           clk,
    input  logic           RST,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [A_W-1:0] in_a,
    input  logic [A_W-1:0] in_b,
    output logic           res_valid,
    input  logic           res_ready,
    output logic [P_W-1:0] res_p,
    output logic [A_W-1:0] dsp_a,
    output logic [A_W-1:0] dsp_b,
    output logic [7:0]     dsp_opmode,
    output logic           dsp_ce,
    output logic           dsp_rst,
    input  logic [P_W-1:0] dsp_p,
    input  logic           dsp_carryout
`ifdef DSP48A1_OVF_FLAG_EN
    ,
    output logic           res_ovf
`endif
);

    localparam int CW = $clog2(N_MAC + 1);

    state_e         state_q, state_d;
    logic [CW-1:0]  iss_cnt_q, iss_cnt_d;
    logic [CW-1:0]  ext_cnt_q, ext_cnt_d;
    logic           res_valid_q, res_valid_d;
    logic [P_W-1:0] res_p_q, res_p_d;
    logic [A_W-1:0] a_q, a_d, b_q, b_d;
    logic           ce_q, ce_d;
    logic           tok_q, tok_d;
    logic [7:0]     tag_q, tag_d;
    logic           rst_q;
    logic           tok_out;
    logic           cap;
    logic           acc_res;

    // Token at the valid-pipe output marks the cycle P holds that product.
    assign cap     = (state_q == DRAIN) && tok_out
                     && (ext_cnt_q == CW'(N_MAC - 1));
    assign acc_res = (state_q == HOLD) && res_ready;

    always_comb begin
        state_d     = state_q;
        iss_cnt_d   = iss_cnt_q;
        ext_cnt_d   = ext_cnt_q;
        res_valid_d = res_valid_q;
        res_p_d     = res_p_q;
        a_d         = a_q;
        b_d         = b_q;
        ce_d        = 1'b0;
        tok_d       = 1'b0;
        tag_d       = tag_q;
        if (tok_out && ce_q) ext_cnt_d = ext_cnt_q + CW'(1);
        unique case (state_q)
            IDLE: begin
                iss_cnt_d = '0;
                state_d   = ISSUE;
            end
            ISSUE: begin
                if (in_valid) begin
                    a_d       = in_a;
                    b_d       = in_b;
                    ce_d      = 1'b1;
                    tok_d     = 1'b1;
                    tag_d     = (iss_cnt_q == '0) ? OPMODE_FIRST : OPMODE_ACC;
                    iss_cnt_d = iss_cnt_q + CW'(1);
                    if (iss_cnt_q == CW'(N_MAC - 1)) state_d = DRAIN;
                end
            end
            DRAIN: begin
                ce_d = 1'b1;
                if (cap) begin
                    res_p_d     = dsp_p;
                    res_valid_d = 1'b1;
                    ext_cnt_d   = '0;
                    state_d     = HOLD;
                end
            end
            HOLD: begin
                if (acc_res) begin
                    res_valid_d = 1'b0;
                    iss_cnt_d   = '0;
                    state_d     = ISSUE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            state_q     <= IDLE;
            iss_cnt_q   <= '0;
            ext_cnt_q   <= '0;
            res_valid_q <= 1'b0;
            res_p_q     <= '0;
            a_q         <= '0;
            b_q         <= '0;
            ce_q        <= 1'b0;
            tok_q       <= 1'b0;
            tag_q       <= '0;
        end else begin
            state_q     <= state_d;
            iss_cnt_q   <= iss_cnt_d;
            ext_cnt_q   <= ext_cnt_d;
            res_valid_q <= res_valid_d;
            res_p_q     <= res_p_d;
            a_q         <= a_d;
            b_q         <= b_d;
            ce_q        <= ce_d;
            tok_q       <= tok_d;
            tag_q       <= tag_d;
        end
    end

    always_ff @(posedge clk) rst_q <= RST;

    dsp_ctrl_pipe #(.W(1), .DEPTH(LATENCY)) u_vld_pipe (
        .clk_i (clk),
        .rst_i (RST),
        .ce_i  (ce_q),
        .d_i   (tok_q),
        .q_o   (tok_out)
    );

    dsp_ctrl_pipe #(.W(8), .DEPTH(OPM_LAG)) u_opm_pipe (
        .clk_i (clk),
        .rst_i (RST),
        .ce_i  (ce_q),
        .d_i   (tag_q),
        .q_o   (dsp_opmode)
    );

`ifdef DSP48A1_OVF_FLAG_EN
    logic ovf_q, res_ovf_q;

    always_ff @(posedge clk) begin
        if (RST) begin
            ovf_q     <= 1'b0;
            res_ovf_q <= 1'b0;
        end else if (cap) begin
            ovf_q     <= 1'b0;
            res_ovf_q <= ovf_q | dsp_carryout;
        end else begin
            if (tok_out && ce_q) ovf_q <= ovf_q | dsp_carryout;
            if (acc_res) res_ovf_q <= 1'b0;
        end
    end

    assign res_ovf = res_ovf_q;
`else
    logic unused_carry;
    assign unused_carry = dsp_carryout;
`endif

    assign in_ready  = (state_q == ISSUE);
    assign res_valid = res_valid_q;
    assign res_p     = res_p_q;
    assign dsp_a     = a_q;
    assign dsp_b     = b_q;
    assign dsp_ce    = ce_q;
    assign dsp_rst   = rst_q;

endmodule
